// File: rtl/rf_forward_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_forward_scoreboard
//
// ID-stage register-forwarding unit. Tracks the destination tags of the
// instructions in flight in a small shift register (entry 1 = EX ...
// entry STAGES = WB). Each cycle it picks a forwarding source for every ID
// read port, or raises a stall when the youngest producer of that register
// has not yet reached the stage from which its result is available.
//
// Parameters:
//   NUM_RD_PORTS      number of ID read ports checked
//   STAGES            downstream stages tracked (1 = EX ... STAGES = WB)
//   ADDR_W            register address width
//   ALU_READY_STAGE   first stage an ALU result can be forwarded from
//   LOAD_READY_STAGE  first stage a load result can be forwarded from
//   SEL_W             width of one select field (derived)
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   id_valid          a valid instruction occupies ID
//   id_rs_addr        read addresses, port p at [p*ADDR_W +: ADDR_W]
//   id_rs_used        port p actually reads its register
//   id_wr_en          ID instruction writes a register
//   id_wr_addr        ID instruction destination register
//   id_is_load        ID instruction is a load
//   flush             kill the ID instruction and the EX entry
//   fwd_sel           per port: 0 = register file, s = forward from stage s
//   stall             hold IF/ID and insert a bubble into EX
//
// Optional feature (macro RF_FWD_PERF_CNT_EN):
//   stall_cnt         saturating count of cycles with stall = 1
//   fwd_cnt           saturating count of cycles with any fwd_sel != 0
// -----------------------------------------------------------------------------
module rf_forward_scoreboard #(
    parameter int NUM_RD_PORTS     = 2,
    parameter int STAGES           = 3,
    parameter int ADDR_W           = 5,
    parameter int ALU_READY_STAGE  = 2,
    parameter int LOAD_READY_STAGE = 3,
    parameter int SEL_W            = $clog2(STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             id_valid,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]   id_rs_addr,
    input  logic [NUM_RD_PORTS-1:0]          id_rs_used,
    input  logic                             id_wr_en,
    input  logic [ADDR_W-1:0]                id_wr_addr,
    input  logic                             id_is_load,
    input  logic                             flush,
    output logic [NUM_RD_PORTS*SEL_W-1:0]    fwd_sel,
    output logic                             stall
`ifdef RF_FWD_PERF_CNT_EN
    ,
    output logic [31:0]                      stall_cnt,
    output logic [31:0]                      fwd_cnt
`endif
);

    localparam logic [SEL_W-1:0] ALU_RDY  = SEL_W'(ALU_READY_STAGE);
    localparam logic [SEL_W-1:0] LOAD_RDY = SEL_W'(LOAD_READY_STAGE);

    // In-flight entries, indexed by stage number
    logic              ent_valid_r [1:STAGES];
    logic [ADDR_W-1:0] ent_addr_r  [1:STAGES];
    logic [SEL_W-1:0]  ent_rdy_r   [1:STAGES];

    // Per-port youngest match information
    logic [NUM_RD_PORTS-1:0] hit_s;
    logic [NUM_RD_PORTS-1:0] late_s;
    logic [SEL_W-1:0]        hit_k_s [NUM_RD_PORTS];

    logic [NUM_RD_PORTS*SEL_W-1:0] fwd_sel_s;
    logic                          stall_s;
    logic                          alloc_s;

    // Youngest-match search per read port; scanning oldest to youngest lets
    // the last hit (lowest stage) win
    always_comb begin
        hit_s  = '0;
        late_s = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            hit_k_s[p] = '0;
        end
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (ent_valid_r[k] &&
                    (ent_addr_r[k] == id_rs_addr[p*ADDR_W +: ADDR_W]) &&
                    (id_rs_addr[p*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) begin
                    hit_s[p]   = 1'b1;
                    hit_k_s[p] = SEL_W'(k);
                    // A younger not-ready match masks any older ready one
                    late_s[p]  = (SEL_W'(k) < ent_rdy_r[k]);
                end else begin
                    hit_s[p] = hit_s[p];
                end
            end
        end
    end

    // Forwarding selects and stall request from the match results
    always_comb begin
        fwd_sel_s = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (id_valid && id_rs_used[p] && hit_s[p] && !late_s[p]) begin
                fwd_sel_s[p*SEL_W +: SEL_W] = hit_k_s[p];
            end else begin
                fwd_sel_s[p*SEL_W +: SEL_W] = {SEL_W{1'b0}};
            end
        end
        // A flushed ID instruction never needs to wait
        if (id_valid && !flush && ((late_s & id_rs_used) != '0)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign fwd_sel = fwd_sel_s;
    assign stall   = stall_s;

    // Register 0 writes are never tracked so r0 can never forward or stall
    assign alloc_s = id_valid && id_wr_en && (id_wr_addr != {ADDR_W{1'b0}}) &&
                     !stall_s && !flush;

    // Tag shift register: entry 1 takes the leaving ID instruction or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= STAGES; k++) begin
                ent_valid_r[k] <= 1'b0;
                ent_addr_r[k]  <= {ADDR_W{1'b0}};
                ent_rdy_r[k]   <= {SEL_W{1'b0}};
            end
        end else begin
            ent_valid_r[1] <= alloc_s;
            ent_addr_r[1]  <= alloc_s ? id_wr_addr : {ADDR_W{1'b0}};
            ent_rdy_r[1]   <= alloc_s ? (id_is_load ? LOAD_RDY : ALU_RDY)
                                      : {SEL_W{1'b0}};
            for (int k = 2; k <= STAGES; k++) begin
                // Flush also kills the instruction currently in EX
                if ((k == 2) && flush) begin
                    ent_valid_r[k] <= 1'b0;
                    ent_addr_r[k]  <= {ADDR_W{1'b0}};
                    ent_rdy_r[k]   <= {SEL_W{1'b0}};
                end else begin
                    ent_valid_r[k] <= ent_valid_r[k-1];
                    ent_addr_r[k]  <= ent_addr_r[k-1];
                    ent_rdy_r[k]   <= ent_rdy_r[k-1];
                end
            end
        end
    end

`ifdef RF_FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] fwd_cnt_r;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
            fwd_cnt_r   <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if ((fwd_sel_s != '0) && (fwd_cnt_r != 32'hFFFF_FFFF)) begin
                fwd_cnt_r <= fwd_cnt_r + 32'd1;
            end else begin
                fwd_cnt_r <= fwd_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign fwd_cnt   = fwd_cnt_r;
`endif

endmodule

// File: tb/tb_rf_forward_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rf_forward_scoreboard
//
// Self-checking bench for rf_forward_scoreboard with default parameters.
// Directed scenarios followed by randomized traffic compared against a
// reference model that keeps a history queue of issued instructions
// (element 0 = most recently issued = stage 1).
// -----------------------------------------------------------------------------
module tb_rf_forward_scoreboard;

    localparam int NP       = 2;
    localparam int STG      = 3;
    localparam int AW       = 5;
    localparam int SW       = 2;
    localparam int ALU_RDY  = 2;
    localparam int LOAD_RDY = 3;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [NP*AW-1:0] id_rs_addr;
    logic [NP-1:0]    id_rs_used;
    logic             id_wr_en;
    logic [AW-1:0]    id_wr_addr;
    logic             id_is_load;
    logic             flush;
    logic [NP*SW-1:0] fwd_sel;
    logic             stall;
`ifdef RF_FWD_PERF_CNT_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rf_forward_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs_addr (id_rs_addr),
        .id_rs_used (id_rs_used),
        .id_wr_en   (id_wr_en),
        .id_wr_addr (id_wr_addr),
        .id_is_load (id_is_load),
        .flush      (flush),
        .fwd_sel    (fwd_sel),
        .stall      (stall)
`ifdef RF_FWD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit            v;
        logic [AW-1:0] a;
        bit            ld;
    } rec_t;

    rec_t             hist[$];
    logic [NP*SW-1:0] exp_sel;
    bit               exp_stall;
    int               m_stall_cnt;
    int               m_fwd_cnt;

    task automatic model_clear();
        rec_t r;
        r.v = 1'b0; r.a = '0; r.ld = 1'b0;
        hist.delete();
        for (int i = 0; i < STG; i++) hist.push_back(r);
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endtask

    // Expected outputs from the in-flight history and the current ID inputs
    task automatic model_eval();
        logic [AW-1:0] rs;
        int            kh;
        int            need;
        exp_sel   = '0;
        exp_stall = 1'b0;
        for (int p = 0; p < NP; p++) begin
            rs = id_rs_addr[p*AW +: AW];
            kh = 0;
            for (int k = 1; k <= STG; k++) begin
                if (kh == 0 && hist[k-1].v && hist[k-1].a == rs && rs != 5'd0) kh = k;
            end
            if (kh != 0 && id_valid && id_rs_used[p]) begin
                need = hist[kh-1].ld ? LOAD_RDY : ALU_RDY;
                if (kh >= need) exp_sel[p*SW +: SW] = SW'(kh);
                else            exp_stall = 1'b1;
            end
        end
        if (flush) exp_stall = 1'b0;
    endtask

    // One clock: advance the model alongside the DUT, return #1 after the edge
    task automatic tick();
        rec_t r;
        bit   wr;
        model_eval();
        wr = id_valid && id_wr_en && (id_wr_addr != 5'd0) && !exp_stall && !flush;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (exp_stall) m_stall_cnt++;
            if (exp_sel != '0) m_fwd_cnt++;
            if (flush) hist[0].v = 1'b0;
            r.v  = wr;
            r.a  = wr ? id_wr_addr : 5'd0;
            r.ld = id_is_load;
            hist.push_front(r);
            void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [1:0] used, input bit wen, input logic [AW-1:0] wa,
                         input bit ld, input bit fl);
        id_valid   = v;
        id_rs_addr = {r1, r0};
        id_rs_used = used;
        id_wr_en   = wen;
        id_wr_addr = wa;
        id_is_load = ld;
        flush      = fl;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: stall=%b sel=%b, want 0/0000", stall, fwd_sel);
        end
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd1, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd2, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd3, 5'd2, 2'b11, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_prestall: stall=%b want 1", stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: stall=%b sel=%b, want 0/0000", stall, fwd_sel);
        end
        model_clear();
        tick();
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL reset_r5: stall=%b sel=%b, want 0/0000", stall, fwd_sel);
        end
    endtask

    task automatic test_alu_back_to_back();
        idle(3);
        drive(1'b1, 5'd1, 5'd2, 2'b00, 1'b1, 5'd3, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b1, 5'd6, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b1 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL alu_cyc1: stall=%b sel=%b, want 1/0000", stall, fwd_sel);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0010) begin
            errors++;
            $display("FAIL alu_cyc2: stall=%b sel=%b, want 0/0010", stall, fwd_sel);
        end
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL alu_after: stall=%b sel=%b, want 0/0000", stall, fwd_sel);
        end
    endtask

    task automatic test_load_use();
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd1, 5'd8, 2'b10, 1'b1, 5'd11, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b1 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL load_stall1: stall=%b sel=%b, want 1/0000", stall, fwd_sel);
        end
        tick();
        checks++;
        if (stall !== 1'b1 || dut.ent_valid_r[1] !== 1'b0) begin
            errors++;
            $display("FAIL load_stall2: stall=%b ent1_valid=%b, want 1/0", stall, dut.ent_valid_r[1]);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b1100 || dut.ent_valid_r[1] !== 1'b0) begin
            errors++;
            $display("FAIL load_fwd: stall=%b sel=%b ent1_valid=%b, want 0/1100/0",
                     stall, fwd_sel, dut.ent_valid_r[1]);
        end
        tick();
    endtask

    task automatic test_youngest();
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd4, 5'd4, 2'b11, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b1010) begin
            errors++;
            $display("FAIL youngest_alu: stall=%b sel=%b, want 0/1010", stall, fwd_sel);
        end
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd4, 5'd4, 2'b11, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b1 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL youngest_load: stall=%b sel=%b, want 1/0000", stall, fwd_sel);
        end
        idle(1);
    endtask

    task automatic test_r0_unused();
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL r0_read: stall=%b sel=%b, want 0/0000", stall, fwd_sel);
        end
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd6, 5'd6, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL unused_ports: stall=%b sel=%b, want 0/0000", stall, fwd_sel);
        end
        tick();
    endtask

    task automatic test_flush();
`ifdef RF_FWD_PERF_CNT_EN
        logic [31:0] cnt_before;
`endif
        idle(3);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd9, 5'd0, 2'b01, 1'b1, 5'd10, 1'b0, 1'b1);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall=%b want 0", stall);
        end
`ifdef RF_FWD_PERF_CNT_EN
        cnt_before = stall_cnt;
`endif
        tick();
        drive(1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (dut.ent_valid_r[1] !== 1'b0 || dut.ent_valid_r[2] !== 1'b0 ||
            stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL flush_after: v1=%b v2=%b stall=%b sel=%b, want 0/0/0/0000",
                     dut.ent_valid_r[1], dut.ent_valid_r[2], stall, fwd_sel);
        end
`ifdef RF_FWD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== cnt_before) begin
            errors++;
            $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, cnt_before);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            model_eval();
            checks++;
            if (stall !== exp_stall || fwd_sel !== exp_sel) begin
                errors++;
                $display("FAIL random[%0d]: stall=%b sel=%b, want %b/%b",
                         n, stall, fwd_sel, exp_stall, exp_sel);
            end
            tick();
        end
`ifdef RF_FWD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'(m_stall_cnt) || fwd_cnt !== 32'(m_fwd_cnt)) begin
            errors++;
            $display("FAIL perf_counts: stall_cnt=%0d fwd_cnt=%0d, want %0d/%0d",
                     stall_cnt, fwd_cnt, m_stall_cnt, m_fwd_cnt);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        model_clear();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_youngest();
        test_r0_unused();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_forward_scoreboard.md
Name: rf_forward_scoreboard

Overview:
- Parametrised successor to the ID-stage register-forwarding unit of the MIPS pipeline.
- Keeps its own shift register of in-flight destination tags, one entry per downstream stage (stage 1 = EX ... stage STAGES = WB).
- Selects the forwarding source for each ID read port, or raises a stall when the matching result is not ready yet.
- Handles per-instruction result latency (ALU vs load), bubble insertion on stall, and flush.

Parameters:
- NUM_RD_PORTS, 2, number of ID register read ports checked.
- STAGES, 3, downstream stages tracked (1 = EX, 2 = MEM, 3 = WB).
- ADDR_W, 5, register address width.
- ALU_READY_STAGE, 2, first stage from which an ALU result may be forwarded.
- LOAD_READY_STAGE, 3, first stage from which a load result may be forwarded.
- SEL_W, $clog2(STAGES+1), width of each select field (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  a valid instruction occupies ID.
- id_rs_addr  in  NUM_RD_PORTS*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- id_rs_used  in  NUM_RD_PORTS  port p actually reads its register.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_addr  in  ADDR_W  destination (rt for immediates, rd for R-type; resolved upstream).
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  kill the ID instruction and the EX entry.
- fwd_sel  out  NUM_RD_PORTS*SEL_W  per port: 0 = register file, s = forward from stage s.
- stall  out  1  hold IF/ID, insert bubble into EX.

Behaviour:
- Reset:
  - All entries invalid; fwd_sel = 0; stall = 0.
  - Reset applies immediately, mid-operation included.
- Entry fields: valid, addr, rdy (ready stage, LOAD_READY_STAGE if load else ALU_READY_STAGE).
- Update at each rising edge, when not in reset:
  - Entries k = 2..STAGES take entry k-1; entry STAGES retires.
  - Entry 1 loads the ID instruction when id_valid & id_wr_en & id_wr_addr != 0 & !stall & !flush; otherwise it loads a bubble.
- Flush:
  - Entry 1 loads a bubble, and entry 2 loads a bubble instead of the old entry 1.
  - Flush wins over stall.
- Match (combinational, 0-cycle latency):
  - Port p matches stage k when entry k is valid, addr == id_rs_addr[p], and id_rs_addr[p] != 0.
  - Priority goes to the youngest match (lowest k).
- fwd_sel[p]:
  - 0 when any of these holds: id_valid = 0, id_rs_used[p] = 0, no match, or the youngest match is not ready (k < rdy).
  - Otherwise k.
- Stall:
  - Asserted when id_valid and, for some used port, the youngest match has k < rdy.
  - Forced to 0 while flush = 1.
- Older matches never override a younger, not-ready match; the port stalls instead.
- Register 0 never forwards and never stalls.
- Same-address write and read from one ID instruction:
  - Its own destination does not affect its own reads.
  - It enters entry 1 only after leaving ID.
- Stall is purely combinational from present state; no internal stall counter.
- A load followed by a dependent instruction with default params: stalls 2 cycles, then forwards from stage 3.

Optional Feature:
- Macro: RF_FWD_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits: a saturating count of cycles with stall = 1.
  - Also adds output fwd_cnt, 32 bits: a saturating count of cycles with any fwd_sel != 0.
  - Both reset to 0 on rst_n low and hold at 32'hFFFF_FFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-stream with three valid entries -> stall = 0, fwd_sel = 0 immediately. After release, an ID read of r5 with no new writes -> fwd_sel = 0.
- ALU to back-to-back consumer: ADD r3 in ID, next cycle ID reads r3 on port 0 -> cycle 1: stall = 1, sel = 0. Cycle 2: stall = 0, sel[0] = 2. Without a new match the following cycle, sel[0] = 0.
- Load-use: LW r8, then consumer reads r8 on port 1 -> stall for 2 cycles, then sel[1] = 3. Stall cycles insert bubbles, checked by the entry-1 valid bit.
- Youngest priority: writes to r4 at stages 3 and 2, ID reads r4 on both ports -> sel = {2,2}, stall = 0. Same with the stage-2 entry a load -> stall = 1.
- r0 and unused ports: ID reads r0 while entry 1 has addr 0 (never allocated), and id_rs_used = 2'b00 with matching addresses -> stall = 0, sel = 0.
- Flush: LW r9 in EX, consumer of r9 in ID, flush = 1 -> stall = 0 that cycle. Next cycle: entries 1 and 2 invalid, so a new read of r9 gives sel = 0. With RF_FWD_PERF_CNT_EN, stall_cnt is unchanged.
